// File: rtl/mem_trace.sv
// Store-trace capture FIFO for the multicycle CPU: one record per rising edge of memwrite.
// Optional idle watchdog is built when MEM_TRACE_WDOG_EN is defined.
module mem_trace #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [31:0]              dataaddr,
    input  logic [31:0]              writedata,
    input  logic [31:0]              pc,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [31:0]              rd_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          wr_rec, head_q, head_d;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [AW:0]   cnt_q, cnt_d;
    logic          mw_q, capture, full, pop, push, ovf_q, last_out;

    assign wr_rec   = '{addr: dataaddr, data: writedata, pc: pc};
    assign capture  = memwrite & ~mw_q;
    assign full     = (cnt_q == CNT_FULL);
    assign rd_valid = (cnt_q != '0);
    assign pop      = rd_valid & rd_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the store.
    assign push     = capture & (~full | pop);
    assign rd_ptr_nx = pop ? rd_ptr + PTR_ONE : rd_ptr;
    // Head comes from the incoming store when nothing older will remain after this edge.
    assign last_out = (cnt_q == '0) | (pop & (cnt_q == CNT_ONE));

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end

    // Read outputs are registered so they hold their last value once the FIFO empties.
    always_comb begin
        head_d = head_q;
        if (cnt_d != '0) begin
            if (last_out) head_d = wr_rec;
            else          head_d = mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mw_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            head_q <= '0;
        end else begin
            mw_q   <= memwrite;
            rd_ptr <= rd_ptr_nx;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (capture && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_rec;
    end

    assign rd_addr  = head_q.addr;
    assign rd_data  = head_q.data;
    assign rd_pc    = head_q.pc;
    assign count    = cnt_q;
    assign overflow = ovf_q;

`ifdef MEM_TRACE_WDOG_EN
    logic [31:0] idle_q, idle_inc;
    logic        tmo_q;

    assign idle_inc = (idle_q == '1) ? idle_q : idle_q + 32'd1;

    // A capture in the expiry cycle clears the counter and suppresses the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else if (capture) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_inc;
            if (idle_inc >= 32'(TIMEOUT)) tmo_q <= 1'b1;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_trace.sv
// Scoreboard bench for mem_trace: stores are queued when driven, compared when the DUT pops.
module tb_mem_trace;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
`ifdef MEM_TRACE_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, memwrite, rd_ready, rd_valid, overflow, timeout;
    logic [31:0] dataaddr, writedata, pc, rd_addr, rd_data, rd_pc;
    logic [3:0]  count;

    rec_t q[$];
    rec_t mon_e;
    bit   exp_ovf;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_trace #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .pc(pc), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pc(rd_pc), .count(count),
        .overflow(overflow), .timeout(timeout)
    );

    // Pops are judged just before the edge that performs them.
    always @(negedge clk) begin
        if (reset && rd_valid && rd_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected got addr=%h data=%h pc=%h want no record", rd_addr, rd_data, rd_pc);
            end else begin
                mon_e = q.pop_front();
                if ({rd_addr, rd_data, rd_pc} !== {mon_e.a, mon_e.d, mon_e.p}) begin
                    n_bad++;
                    $display("FAIL pop_record got %h/%h/%h want %h/%h/%h",
                             rd_addr, rd_data, rd_pc, mon_e.a, mon_e.d, mon_e.p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void sb_push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        rec_t r;
        r.a = a; r.d = d; r.p = p;
        if (q.size() < DEPTH || rd_ready) q.push_back(r);
        else exp_ovf = 1'b1;
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        dataaddr = a; writedata = d; pc = p; memwrite = 1'b1;
        sb_push(a, d, p);
        step();
        memwrite = 1'b0;
        step();
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step();
        rd_ready = 1'b0;
        n_cmp++;
        if (q.size() != 0 || count !== 4'd0 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty got left=%0d count=%0d rd_valid=%0b want 0/0/0", q.size(), count, rd_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; memwrite = 1'b0; rd_ready = 1'b0;
        dataaddr = '0; writedata = '0; pc = '0;
        #12;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL reset_flags got ovf=%0b tmo=%0b want 0/0", overflow, timeout); end
        n_cmp++; if ({rd_addr, rd_data, rd_pc} !== 96'd0) begin n_bad++; $display("FAIL reset_rd_bus got %h/%h/%h want 0", rd_addr, rd_data, rd_pc); end
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete(); exp_ovf = 1'b0;
    endtask

    task automatic test_watchdog();
        repeat (TIMEOUT - 1) step();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL wdog_before got %0b want 0", timeout); end
        n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL idle_state got v=%0b c=%0d want 0/0", rd_valid, count); end
        step();
        n_cmp++; if (timeout !== WDOG) begin n_bad++; $display("FAIL wdog_expiry got %0b want %0b", timeout, WDOG); end
    endtask

    task automatic test_single();
        dataaddr = 32'd6; writedata = 32'd6; pc = 32'h18; memwrite = 1'b1;
        sb_push(32'd6, 32'd6, 32'h18);
        step();
        memwrite = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1 || count !== 4'd1) begin n_bad++; $display("FAIL single_visible got v=%0b c=%0d want 1/1", rd_valid, count); end
        n_cmp++; if ({rd_addr, rd_data, rd_pc} !== {32'd6, 32'd6, 32'h18}) begin n_bad++; $display("FAIL single_head got %h/%h/%h want 6/6/18", rd_addr, rd_data, rd_pc); end
        drain(1);
    endtask

    task automatic test_held();
        dataaddr = 32'd4; writedata = 32'd5; pc = 32'h20; memwrite = 1'b1;
        sb_push(32'd4, 32'd5, 32'h20);
        step();
        writedata = 32'h55;
        step(); step();
        memwrite = 1'b0;
        step();
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL held_count got %0d want 1", count); end
        drain(1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) store(32'h100 + 32'(i * 4), 32'(i), 32'h40 + 32'(i * 4));
        n_cmp++; if (count !== 4'(q.size())) begin n_bad++; $display("FAIL ovf_count got %0d want %0d", count, q.size()); end
        n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag got %0b want %0b", overflow, exp_ovf); end
        drain(DEPTH);
        n_cmp++; if (rd_data !== 32'd8) begin n_bad++; $display("FAIL empty_hold got %0d want 8", rd_data); end
    endtask

    task automatic test_full_pop();
        reset = 1'b0; #2; reset = 1'b1;
        q.delete(); exp_ovf = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(32'h300 + 32'(i), 32'h200 + 32'(i), 32'h80 + 32'(i));
        n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin n_bad++; $display("FAIL full_state got c=%0d ovf=%0b want 8/0", count, overflow); end
        rd_ready = 1'b1;
        dataaddr = 32'h3AA; writedata = 32'h2AA; pc = 32'h8AA; memwrite = 1'b1;
        sb_push(32'h3AA, 32'h2AA, 32'h8AA);
        step();
        memwrite = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin n_bad++; $display("FAIL full_push_pop got c=%0d ovf=%0b want 8/0", count, overflow); end
        drain(DEPTH);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) store(32'h500 + 32'(i), 32'h600 + 32'(i), 32'h700 + 32'(i));
        n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL mid_count got %0d want 5", count); end
        #2 reset = 1'b0;
        #1;
        q.delete();
        n_cmp++; if (rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_ctrl got v=%0b c=%0d ovf=%0b tmo=%0b want 0", rd_valid, count, overflow, timeout); end
        n_cmp++; if ({rd_addr, rd_data, rd_pc} !== 96'd0) begin n_bad++; $display("FAIL mid_reset_bus got %h/%h/%h want 0", rd_addr, rd_data, rd_pc); end
        step(); step();
        reset = 1'b1;
        store(32'h77, 32'h99, 32'h1C);
        n_cmp++; if (count !== 4'd1 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL post_reset_store got c=%0d v=%0b want 1/1", count, rd_valid); end
        drain(1);
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_single();
        test_held();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
